// File: rtl/vga_sprite_compositor_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and defaults for the VGA sprite compositor.
//   rgb12_t      packed 12-bit colour, r in [11:8], g in [7:4], b in [3:0]
//   hit_state_t  hit-capture FSM states
//   *_DEF        default raster size and layer colours
//   scanline_dim halves every channel (used only when VGA_SCANLINE_EN is set)
// -----------------------------------------------------------------------------
package vga_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   typedef enum logic {
      ARMED    = 1'b0,
      CAPTURED = 1'b1
   } hit_state_t;

   localparam int     H_VISIBLE_DEF   = 640;
   localparam int     V_VISIBLE_DEF   = 480;
   localparam rgb12_t ALIENA_RGB_DEF  = 12'hF0F;
   localparam rgb12_t ALIENB_RGB_DEF  = 12'h0FF;
   localparam rgb12_t PLAYER_RGB_DEF  = 12'h0F0;
   localparam rgb12_t MISSILE_RGB_DEF = 12'hFF0;
   localparam rgb12_t BG_RGB_DEF      = 12'h000;

   function automatic rgb12_t scanline_dim(input rgb12_t c);
      rgb12_t d;
      d.r = c.r >> 1;
      d.g = c.g >> 1;
      d.b = c.b >> 1;
      return d;
   endfunction

endpackage

// File: rtl/vga_sprite_compositor_if.sv
// -----------------------------------------------------------------------------
// vga_sprite_compositor_if
// Hit-report handshake between the compositor and the game-control peripheral.
//   hit_valid   record pending (compositor -> firmware)
//   hit_row     row of the captured hit
//   hit_column  column of the captured hit
//   hit_ack     record consumed (firmware -> compositor)
// Modports: master = compositor side, slave = consumer side.
// -----------------------------------------------------------------------------
interface vga_sprite_compositor_if;

   logic        hit_valid;
   logic [11:0] hit_row;
   logic [11:0] hit_column;
   logic        hit_ack;

   modport master (output hit_valid, output hit_row, output hit_column, input hit_ack);
   modport slave  (input hit_valid, input hit_row, input hit_column, output hit_ack);

endinterface

// File: rtl/vga_layer_mux.sv
// -----------------------------------------------------------------------------
// vga_layer_mux
// Combinational fixed-priority layer select:
//   missile > player > alienB > alienA > background; blanked to 0 outside
//   the visible area. A layer is on when its bounding box is active and its
//   pixel is non-zero.
// Ports:
//   i_video_on             visible-area flag
//   i_*_pix / i_*_active   per-layer pixel and bounding box
//   o_rgb                  selected colour
// -----------------------------------------------------------------------------
module vga_layer_mux
   import vga_pkg::*;
#(
   parameter rgb12_t ALIENA_RGB  = ALIENA_RGB_DEF,
   parameter rgb12_t ALIENB_RGB  = ALIENB_RGB_DEF,
   parameter rgb12_t PLAYER_RGB  = PLAYER_RGB_DEF,
   parameter rgb12_t MISSILE_RGB = MISSILE_RGB_DEF,
   parameter rgb12_t BG_RGB      = BG_RGB_DEF
) (
   input  logic       i_video_on,
   input  logic [3:0] i_aliena_pix,
   input  logic       i_aliena_active,
   input  logic [3:0] i_alienb_pix,
   input  logic       i_alienb_active,
   input  logic [3:0] i_player_pix,
   input  logic       i_player_active,
   input  logic [3:0] i_missile_pix,
   input  logic       i_missile_active,
   output rgb12_t     o_rgb
);

   always_comb begin
      // NOTE: o_rgb gets a value before any branch so no path leaves it unassigned (no latch).
      o_rgb = BG_RGB;
      if (!i_video_on)
         o_rgb = '0;
      else if (i_missile_active && (i_missile_pix != 4'd0))
         o_rgb = MISSILE_RGB;
      else if (i_player_active && (i_player_pix != 4'd0))
         o_rgb = PLAYER_RGB;
      else if (i_alienb_active && (i_alienb_pix != 4'd0))
         o_rgb = ALIENB_RGB;
      else if (i_aliena_active && (i_aliena_pix != 4'd0))
         o_rgb = ALIENA_RGB;
   end

endmodule

// File: rtl/vga_sprite_compositor.sv
// -----------------------------------------------------------------------------
// vga_sprite_compositor
// Merges alien/player/missile sprite pixels into registered 12-bit VGA colour
// through a 2-stage pipeline (S1: selected colour + syncs, S2: outputs), with
// the syncs delayed identically. Captures the first missile/alienB overlap of
// each frame and reports it over a valid/ack handshake.
// Ports:
//   clk, rst                     pixel clock, synchronous active-high reset
//   pixel_row/pixel_column       raster position from the timing generator
//   video_on, hsync_in, vsync_in visible flag and active-low syncs
//   alien*/player/missile        per-layer pixel and bounding-box inputs
//   vga_r/vga_g/vga_b            colour outputs
//   hsync_out/vsync_out          syncs delayed to match colour
//   hit_bus (master)             hit_valid/hit_row/hit_column out, hit_ack in
//   hit_drop_count               saturating count of hits lost while pending
//   frame_tick                   one-cycle pulse per frame
// Optional: define VGA_SCANLINE_EN to halve colour on odd rows.
// -----------------------------------------------------------------------------
module vga_sprite_compositor
   import vga_pkg::*;
#(
   parameter int     H_VISIBLE   = H_VISIBLE_DEF,
   parameter int     V_VISIBLE   = V_VISIBLE_DEF,
   parameter rgb12_t ALIENA_RGB  = ALIENA_RGB_DEF,
   parameter rgb12_t ALIENB_RGB  = ALIENB_RGB_DEF,
   parameter rgb12_t PLAYER_RGB  = PLAYER_RGB_DEF,
   parameter rgb12_t MISSILE_RGB = MISSILE_RGB_DEF,
   parameter rgb12_t BG_RGB      = BG_RGB_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [11:0]                     pixel_row,
   input  logic [11:0]                     pixel_column,
   input  logic                            video_on,
   input  logic                            hsync_in,
   input  logic                            vsync_in,
   input  logic [3:0]                      alienA_pix,
   input  logic                            alienA_active,
   input  logic [3:0]                      alienB_pix,
   input  logic                            alienB_active,
   input  logic [3:0]                      player_pix,
   input  logic                            player_active,
   input  logic [3:0]                      missile_pix,
   input  logic                            missile_active,
   output logic [3:0]                      vga_r,
   output logic [3:0]                      vga_g,
   output logic [3:0]                      vga_b,
   output logic                            hsync_out,
   output logic                            vsync_out,
   vga_sprite_compositor_if.master         hit_bus,
   output logic [7:0]                      hit_drop_count,
   output logic                            frame_tick
);

   rgb12_t     w_mux_rgb;
   rgb12_t     w_s1_rgb;
   rgb12_t     r_s1_rgb;
   rgb12_t     r_s2_rgb;
   logic       r_s1_hs, r_s1_vs;
   logic       r_s2_hs, r_s2_vs;
   hit_state_t r_state;
   logic       r_hit_valid;
   logic [11:0] r_hit_row, r_hit_column;
   logic [7:0] r_drop_count;
   logic       r_frame_tick;
   logic       w_overlap;
   logic       w_capture;

   vga_layer_mux #(
      .ALIENA_RGB  (ALIENA_RGB),
      .ALIENB_RGB  (ALIENB_RGB),
      .PLAYER_RGB  (PLAYER_RGB),
      .MISSILE_RGB (MISSILE_RGB),
      .BG_RGB      (BG_RGB)
   ) u_layer_mux (
      .i_video_on       (video_on),
      .i_aliena_pix     (alienA_pix),
      .i_aliena_active  (alienA_active),
      .i_alienb_pix     (alienB_pix),
      .i_alienb_active  (alienB_active),
      .i_player_pix     (player_pix),
      .i_player_active  (player_active),
      .i_missile_pix    (missile_pix),
      .i_missile_active (missile_active),
      .o_rgb            (w_mux_rgb)
   );

`ifdef VGA_SCANLINE_EN
   assign w_s1_rgb = pixel_row[0] ? scanline_dim(w_mux_rgb) : w_mux_rgb;
`else
   assign w_s1_rgb = w_mux_rgb;
`endif

   // Colour/sync pipeline. Syncs are active-low, so they reset high.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_s1_rgb <= '0;
         r_s1_hs  <= 1'b1;
         r_s1_vs  <= 1'b1;
         r_s2_rgb <= '0;
         r_s2_hs  <= 1'b1;
         r_s2_vs  <= 1'b1;
      end else begin
         r_s1_rgb <= w_s1_rgb;
         r_s1_hs  <= hsync_in;
         r_s1_vs  <= vsync_in;
         r_s2_rgb <= r_s1_rgb;
         r_s2_hs  <= r_s1_hs;
         r_s2_vs  <= r_s1_vs;
      end
   end

   // The raster bounds check only guards against a timing generator that
   // asserts video_on outside the visible window; normally it is redundant.
   assign w_overlap = missile_active && (missile_pix != 4'd0) &&
                      alienB_active  && (alienB_pix  != 4'd0) &&
                      video_on &&
                      (pixel_row    < 12'(V_VISIBLE)) &&
                      (pixel_column < 12'(H_VISIBLE));
   assign w_capture = (r_state == ARMED) && w_overlap;

   // Hit FSM, record handshake, drop counter and frame tick. The FSM re-arms
   // on the registered tick, which always falls in blanking, so it can never
   // coincide with a capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ARMED;
         r_hit_valid  <= 1'b0;
         r_hit_row    <= '0;
         r_hit_column <= '0;
         r_drop_count <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= (pixel_row == 12'(V_VISIBLE)) && (pixel_column == 12'd0);

         case (r_state)
            ARMED:    if (w_overlap)    r_state <= CAPTURED;
            CAPTURED: if (r_frame_tick) r_state <= ARMED;
            default:                    r_state <= ARMED;
         endcase

         if (w_capture) begin
            // An ack in the same cycle frees the slot, so the new record wins.
            if (!r_hit_valid || hit_bus.hit_ack) begin
               r_hit_valid  <= 1'b1;
               r_hit_row    <= pixel_row;
               r_hit_column <= pixel_column;
            end else if (r_drop_count != 8'hFF) begin
               r_drop_count <= r_drop_count + 8'd1;
            end
         end else if (r_hit_valid && hit_bus.hit_ack) begin
            r_hit_valid <= 1'b0;
         end
      end
   end

   assign vga_r              = r_s2_rgb.r;
   assign vga_g              = r_s2_rgb.g;
   assign vga_b              = r_s2_rgb.b;
   assign hsync_out          = r_s2_hs;
   assign vsync_out          = r_s2_vs;
   assign hit_bus.hit_valid  = r_hit_valid;
   assign hit_bus.hit_row    = r_hit_row;
   assign hit_bus.hit_column = r_hit_column;
   assign hit_drop_count     = r_drop_count;
   assign frame_tick         = r_frame_tick;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_vga_sprite_compositor
// Directed stimulus for vga_sprite_compositor. A behavioural reference model
// (colour rule + 2-cycle delay queue, plus a frame-level hit record) is
// compared against the DUT on every falling edge; hand-computed literal checks
// pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_vga_sprite_compositor;

   localparam logic [11:0] C_ALIENA  = 12'hF0F;
   localparam logic [11:0] C_ALIENB  = 12'h0FF;
   localparam logic [11:0] C_PLAYER  = 12'h0F0;
   localparam logic [11:0] C_MISSILE = 12'hFF0;
   localparam logic [11:0] C_BG      = 12'h000;
   localparam int          V_VIS     = 480;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] pixel_row = '0, pixel_column = '0;
   logic        video_on = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1;
   logic [3:0]  alienA_pix = '0, alienB_pix = '0, player_pix = '0, missile_pix = '0;
   logic        alienA_active = 1'b0, alienB_active = 1'b0;
   logic        player_active = 1'b0, missile_active = 1'b0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        hsync_out, vsync_out, frame_tick;
   logic [7:0]  hit_drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   vga_sprite_compositor_if hit_bus ();

   vga_sprite_compositor dut (
      .clk            (clk),
      .rst            (rst),
      .pixel_row      (pixel_row),
      .pixel_column   (pixel_column),
      .video_on       (video_on),
      .hsync_in       (hsync_in),
      .vsync_in       (vsync_in),
      .alienA_pix     (alienA_pix),
      .alienA_active  (alienA_active),
      .alienB_pix     (alienB_pix),
      .alienB_active  (alienB_active),
      .player_pix     (player_pix),
      .player_active  (player_active),
      .missile_pix    (missile_pix),
      .missile_active (missile_active),
      .vga_r          (vga_r),
      .vga_g          (vga_g),
      .vga_b          (vga_b),
      .hsync_out      (hsync_out),
      .vsync_out      (vsync_out),
      .hit_bus        (hit_bus),
      .hit_drop_count (hit_drop_count),
      .frame_tick     (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } pix_t;

   pix_t        pipe[$];
   pix_t        m_out;
   bit          model_on = 1'b0;
   bit          m_armed, m_valid, m_tick;
   logic [11:0] m_row, m_col;
   int          m_drop;

   function automatic logic [11:0] model_colour();
      logic [11:0] c;
      if (!video_on)                                c = 12'h000;
      else if (missile_active && missile_pix != 0)  c = C_MISSILE;
      else if (player_active  && player_pix  != 0)  c = C_PLAYER;
      else if (alienB_active  && alienB_pix  != 0)  c = C_ALIENB;
      else if (alienA_active  && alienA_pix  != 0)  c = C_ALIENA;
      else                                          c = C_BG;
`ifdef VGA_SCANLINE_EN
      if (pixel_row[0]) c = {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
`endif
      return c;
   endfunction

   always @(posedge clk) begin
      bit overlap, capture;
      if (rst) begin
         model_on = 1'b1;
         m_out    = '{12'h000, 1'b1, 1'b1};
         pipe     = {m_out};
         m_armed  = 1'b1;
         m_valid  = 1'b0;
         m_row    = '0;
         m_col    = '0;
         m_drop   = 0;
         m_tick   = 1'b0;
      end else if (model_on) begin
         pipe.push_back('{model_colour(), hsync_in, vsync_in});
         m_out   = pipe.pop_front();
         overlap = missile_active && missile_pix != 0 && alienB_active &&
                   alienB_pix != 0 && video_on;
         capture = m_armed && overlap;
         if (capture) begin
            if (!m_valid || hit_bus.hit_ack) begin
               m_valid = 1'b1;
               m_row   = pixel_row;
               m_col   = pixel_column;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end else if (m_valid && hit_bus.hit_ack) begin
            m_valid = 1'b0;
         end
         if (capture)     m_armed = 1'b0;
         else if (m_tick) m_armed = 1'b1;
         m_tick = (pixel_row == 12'(V_VIS)) && (pixel_column == 12'd0);
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model_rgb",  {vga_r, vga_g, vga_b}, m_out.rgb);
         check("model_hs",   hsync_out, m_out.hs);
         check("model_vs",   vsync_out, m_out.vs);
         check("model_tick", frame_tick, m_tick);
         check("model_valid", hit_bus.hit_valid, m_valid);
         check("model_drop",  hit_drop_count, m_drop);
         if (m_valid) begin
            check("model_row", hit_bus.hit_row, m_row);
            check("model_col", hit_bus.hit_column, m_col);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic layers_off();
      alienA_active = 0; alienB_active = 0; player_active = 0; missile_active = 0;
      alienA_pix = 0; alienB_pix = 0; player_pix = 0; missile_pix = 0;
   endtask

   task automatic set_pos(input int row, input int col);
      pixel_row    = 12'(row);
      pixel_column = 12'(col);
   endtask

   // Present one layer combination for one cycle, then expect its colour 2 edges later.
   task automatic colour_case(input string name, input logic [11:0] exp);
      step();
      layers_off();
      step();
      check(name, {vga_r, vga_g, vga_b}, exp);
   endtask

   task automatic overlap_at(input int row, input int col, input logic ack);
      set_pos(row, col);
      video_on = 1; alienB_active = 1; alienB_pix = 4'h3;
      missile_active = 1; missile_pix = 4'h2;
      hit_bus.hit_ack = ack;
      step();
      layers_off();
      hit_bus.hit_ack = 0;
      step();
   endtask

   task automatic frame_boundary();
      set_pos(V_VIS, 0);
      video_on = 0;
      step();
      set_pos(0, 0);
      video_on = 1;
      step();
   endtask

   task automatic ack_pulse();
      hit_bus.hit_ack = 1;
      step();
      hit_bus.hit_ack = 0;
      step();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rgb"},   {vga_r, vga_g, vga_b}, 12'h000);
      check({tag, "_hs"},    hsync_out, 1'b1);
      check({tag, "_vs"},    vsync_out, 1'b1);
      check({tag, "_valid"}, hit_bus.hit_valid, 1'b0);
      check({tag, "_row"},   hit_bus.hit_row, 12'd0);
      check({tag, "_col"},   hit_bus.hit_column, 12'd0);
      check({tag, "_drop"},  hit_drop_count, 8'd0);
      check({tag, "_tick"},  frame_tick, 1'b0);
   endtask

   initial begin
      hit_bus.hit_ack = 1'b0;
      rst = 1;
      step();
      step();
      check_reset_values("reset");
      rst = 0;
      set_pos(10, 10);

      // Priority and latency (row 10 is even, so no dimming either way).
      alienB_active = 1; alienB_pix = 4'hF; missile_active = 1; missile_pix = 4'h1;
      colour_case("prio_missile_over_alienb", C_MISSILE);
      alienB_active = 1; alienB_pix = 4'hF; missile_active = 1; missile_pix = 4'h0;
      colour_case("prio_missile_pix0", C_ALIENB);
      player_active = 1; player_pix = 4'h3; alienA_active = 1; alienA_pix = 4'h2;
      colour_case("prio_player_over_aliena", C_PLAYER);
      alienA_active = 1; alienA_pix = 4'h7;
      colour_case("prio_aliena_only", C_ALIENA);
      alienA_active = 1; alienA_pix = 4'h0;
      colour_case("prio_active_pix0_bg", C_BG);

      // Blanking.
      video_on = 0;
      alienA_active = 1; alienA_pix = 1; alienB_active = 1; alienB_pix = 1;
      player_active = 1; player_pix = 1; missile_active = 1; missile_pix = 1;
      colour_case("blank_all_layers", 12'h000);
      video_on = 1;

      // hsync low for one input cycle appears exactly 2 edges later.
      hsync_in = 0;
      step();
      hsync_in = 1;
      check("hsync_n_plus_1", hsync_out, 1'b1);
      step();
      check("hsync_n_plus_2", hsync_out, 1'b0);
      step();
      check("hsync_n_plus_3", hsync_out, 1'b1);

      // The FF0 case above overlapped at (10,10); clear it and move to a new frame.
      check("early_capture_row", hit_bus.hit_row, 12'd10);
      ack_pulse();
      check("ack_clears_valid", hit_bus.hit_valid, 1'b0);
      set_pos(V_VIS, 0);
      video_on = 0;
      step();
      check("frame_tick_pulse", frame_tick, 1'b1);
      set_pos(0, 0);
      video_on = 1;
      step();
      check("frame_tick_single", frame_tick, 1'b0);

      // Ack while nothing pending is ignored.
      ack_pulse();
      check("stray_ack_ignored", hit_bus.hit_valid, 1'b0);

      // First hit of frame wins; later overlaps in the same frame are ignored.
      overlap_at(100, 320, 0);
      overlap_at(101, 5, 0);
      check("first_hit_valid", hit_bus.hit_valid, 1'b1);
      check("first_hit_row",   hit_bus.hit_row, 12'd100);
      check("first_hit_col",   hit_bus.hit_column, 12'd320);
      check("first_hit_nodrop", hit_drop_count, 8'd0);

      // No ack across two more frames, each with an overlap: two drops.
      frame_boundary();
      overlap_at(150, 7, 0);
      frame_boundary();
      overlap_at(160, 8, 0);
      check("noack_row",  hit_bus.hit_row, 12'd100);
      check("noack_col",  hit_bus.hit_column, 12'd320);
      check("noack_drop", hit_drop_count, 8'd2);

      // Capture with ack in the same cycle replaces the record.
      frame_boundary();
      overlap_at(222, 33, 1);
      check("replace_valid", hit_bus.hit_valid, 1'b1);
      check("replace_row",   hit_bus.hit_row, 12'd222);
      check("replace_col",   hit_bus.hit_column, 12'd33);
      check("replace_drop",  hit_drop_count, 8'd2);

      // Mid-frame reset with a record pending, then a hit later in the same frame.
      frame_boundary();
      overlap_at(190, 1, 0);
      set_pos(200, 0);
      rst = 1;
      step();
      check_reset_values("midreset");
      rst = 0;
      overlap_at(300, 44, 0);
      check("post_reset_valid", hit_bus.hit_valid, 1'b1);
      check("post_reset_row",   hit_bus.hit_row, 12'd300);
      check("post_reset_col",   hit_bus.hit_column, 12'd44);

      // Drop counter saturates.
      for (int i = 0; i < 260; i++) begin
         frame_boundary();
         overlap_at(50 + (i % 100), i, 0);
      end
      check("drop_saturated", hit_drop_count, 8'd255);
      check("sat_keeps_row",  hit_bus.hit_row, 12'd300);

      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
